// File: rtl/fifo_read_ctrl.sv
// Read-side FIFO controller: issues pops against a 1-cycle-latency read port,
// holds returned words in a 2-entry skid buffer and streams them out on valid/ready.
module fifo_read_ctrl #(
   parameter int DATAWIDTH = 8,
   parameter int CNTWIDTH  = 16
) (
   input  logic                 i_rd_clk,
   input  logic                 i_rd_rst,
   input  logic                 i_enable,
   input  logic                 i_fifo_empty,
   input  logic [DATAWIDTH-1:0] i_fifo_rd_data,
   output logic                 o_fifo_rd_en,
   output logic [DATAWIDTH-1:0] o_out_data,
   output logic                 o_out_valid,
   input  logic                 i_out_ready,
   output logic [CNTWIDTH-1:0]  o_word_count,
   output logic                 o_busy
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               r_state;
   logic [1:0]           r_occ;
   logic                 r_inflight;
   logic [DATAWIDTH-1:0] r_buf0;
   logic [DATAWIDTH-1:0] r_buf1;
   logic [CNTWIDTH-1:0]  r_word_count;

   logic                 w_pop;
   logic [1:0]           w_slots;
   logic [1:0]           w_occ_after_pop;
   logic                 w_rd_en;

   assign w_pop           = (r_occ != 2'd0) & i_out_ready;
   assign w_slots         = r_occ + {1'b0, r_inflight};
   assign w_occ_after_pop = r_occ - {1'b0, w_pop};

   // A read may reissue with both slots committed only when the head leaves this cycle.
   assign w_rd_en = i_rd_rst & i_enable & ~i_fifo_empty &
                    ((w_slots < 2'd2) | ((w_slots == 2'd2) & w_pop));

   assign o_fifo_rd_en = w_rd_en;
   assign o_out_data   = r_buf0;
   assign o_out_valid  = (r_occ != 2'd0);
   assign o_word_count = r_word_count;
   assign o_busy       = (r_state != IDLE);

   // Head lives in r_buf0; a returning word lands after any same-edge shift.
   always_ff @(posedge i_rd_clk or negedge i_rd_rst) begin
      if (!i_rd_rst) begin
         r_buf0       <= '0;
         r_buf1       <= '0;
         r_occ        <= 2'd0;
         r_inflight   <= 1'b0;
         r_word_count <= '0;
      end else begin
         if (w_pop) begin
            r_buf0 <= r_buf1;
         end
         if (r_inflight) begin
            if (w_occ_after_pop == 2'd0) begin
               r_buf0 <= i_fifo_rd_data;
            end else begin
               r_buf1 <= i_fifo_rd_data;
            end
         end
         r_occ      <= w_occ_after_pop + {1'b0, r_inflight};
         r_inflight <= w_rd_en;
         if (w_pop) begin
            r_word_count <= r_word_count + {{(CNTWIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge i_rd_clk or negedge i_rd_rst) begin
      if (!i_rd_rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_rd_en) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (!i_enable && (w_slots != 2'd0)) begin
                  r_state <= DRAIN;
               end else if ((w_slots == 2'd0) && !w_rd_en) begin
                  r_state <= IDLE;
               end
            end
            DRAIN: begin
               if (i_enable && w_rd_en) begin
                  r_state <= RUN;
               end else if (w_slots == 2'd0) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a queue-based FIFO environment plus a behavioural
// model of the read controller, checked every cycle, with directed and random phases.
module tb_fifo_read_ctrl;

   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rstN = 1'b1;
   logic          enable = 1'b0;
   logic          fifoEmpty = 1'b1;
   logic [DW-1:0] fifoRdData = '0;
   logic          fifoRdEn;
   logic [DW-1:0] outData;
   logic          outValid;
   logic          outReady = 1'b0;
   logic [CW-1:0] wordCount;
   logic          busy;

   int total = 0;
   int bad = 0;

   // Environment: FIFO contents and the order in which words were written
   logic [DW-1:0] fifoQ[$];
   logic [DW-1:0] sentQ[$];
   int            readCount = 0;
   int            validCycles = 0;
   int            cycleNo = 0;
   logic          doFifoPop = 1'b0;
   logic [DW-1:0] accData[$];
   int            accCycle[$];

   // Model: skid buffer contents as a queue, one in-flight flag, count, activity state
   logic [DW-1:0] mq[$];
   logic          mInflight = 1'b0;
   logic [CW-1:0] mCount = '0;
   int            mState = 0;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

   fifo_read_ctrl #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
      .i_rd_clk      (clk),
      .i_rd_rst      (rstN),
      .i_enable      (enable),
      .i_fifo_empty  (fifoEmpty),
      .i_fifo_rd_data(fifoRdData),
      .o_fifo_rd_en  (fifoRdEn),
      .o_out_data    (outData),
      .o_out_valid   (outValid),
      .i_out_ready   (outReady),
      .o_word_count  (wordCount),
      .o_busy        (busy)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cycleNo);
      end
   endtask

   task automatic pushWord(input logic [DW-1:0] v);
      fifoQ.push_back(v);
      sentQ.push_back(v);
      fifoEmpty = 1'b0;
   endtask

   task automatic applyStimulus(input logic en, input logic rdy);
      enable   = en;
      outReady = rdy;
   endtask

   // Compares every output with the model, scoreboards accepted words, advances the model
   task automatic checkOutput();
      int   occ;
      int   slots;
      logic pop;
      logic expRdEn;
      if (!rstN) begin
         checkVal("rst_rd_en", fifoRdEn, 0);
         checkVal("rst_valid", outValid, 0);
         checkVal("rst_data", outData, 0);
         checkVal("rst_count", wordCount, 0);
         checkVal("rst_busy", busy, 0);
         mq.delete();
         mInflight = 1'b0;
         mCount    = '0;
         mState    = M_IDLE;
         doFifoPop = 1'b0;
         return;
      end
      occ     = mq.size();
      slots   = occ + int'(mInflight);
      pop     = (occ != 0) && outReady;
      expRdEn = enable && !fifoEmpty && ((slots < 2) || ((slots == 2) && pop));
      checkVal("rd_en", fifoRdEn, expRdEn);
      checkVal("out_valid", outValid, occ != 0);
      if (occ != 0) checkVal("out_data", outData, mq[0]);
      checkVal("word_count", wordCount, mCount);
      checkVal("busy", busy, mState != M_IDLE);
      if (outValid && outReady) begin
         if (sentQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL sb_extra actual=%0h expected=none at cycle %0d", outData, cycleNo);
         end else begin
            checkVal("sb_order", outData, sentQ.pop_front());
         end
         accData.push_back(outData);
         accCycle.push_back(cycleNo);
      end
      if (outValid) validCycles++;
      if (pop) void'(mq.pop_front());
      if (mInflight) mq.push_back(fifoRdData);
      case (mState)
         M_IDLE:  if (expRdEn) mState = M_RUN;
         M_RUN: begin
            if (!enable && slots != 0) mState = M_DRAIN;
            else if (slots == 0 && !expRdEn) mState = M_IDLE;
         end
         default: begin
            if (enable && expRdEn) mState = M_RUN;
            else if (slots == 0) mState = M_IDLE;
         end
      endcase
      mInflight = expRdEn;
      if (pop) mCount = mCount + 1'b1;
      doFifoPop = fifoRdEn;
   endtask

   // One clock cycle, entered and left at the falling edge
   task automatic tick();
      #1;
      checkOutput();
      @(posedge clk);
      #1;
      if (doFifoPop) begin
         readCount++;
         if (fifoQ.size() > 0) fifoRdData = fifoQ.pop_front();
         else fifoRdData = DW'($urandom);
      end else begin
         fifoRdData = DW'($urandom);
      end
      @(negedge clk);
      fifoEmpty = (fifoQ.size() == 0);
      cycleNo++;
   endtask

   task automatic doReset();
      rstN = 1'b0;
      fifoQ.delete();
      sentQ.delete();
      fifoEmpty = 1'b1;
      #1;
      checkVal("arst_rd_en", fifoRdEn, 0);
      checkVal("arst_valid", outValid, 0);
      checkVal("arst_data", outData, 0);
      checkVal("arst_count", wordCount, 0);
      checkVal("arst_busy", busy, 0);
      tick();
      tick();
      rstN = 1'b1;
   endtask

   initial begin
      int            start;
      logic [DW-1:0] held;
      @(negedge clk);
      doReset();

      // Streaming 0x01..0x10
      for (int i = 1; i <= 16; i++) pushWord(DW'(i));
      applyStimulus(1'b1, 1'b1);
      accData.delete(); accCycle.delete();
      start = cycleNo;
      for (int i = 0; i < 24; i++) tick();
      checkVal("stream_n", accData.size(), 16);
      for (int i = 0; i < accData.size() && i < 16; i++) begin
         checkVal("stream_data", accData[i], i + 1);
         checkVal("stream_cycle", accCycle[i] - start, i + 2);
      end
      checkVal("stream_count", wordCount, 0);
      checkVal("stream_busy", busy, 0);

      // Backpressure: 5 stalled cycles mid-stream
      doReset();
      for (int i = 0; i < 10; i++) pushWord(DW'(8'h20 + i));
      applyStimulus(1'b1, 1'b1);
      accData.delete(); accCycle.delete();
      start = cycleNo;
      for (int i = 0; i < 4; i++) tick();
      applyStimulus(1'b1, 1'b0);
      #1;
      held = outData;
      checkVal("bp_held_value", held, 8'h22);
      for (int i = 0; i < 5; i++) begin
         checkVal("bp_hold", outData, held);
         checkVal("bp_valid", outValid, 1);
         checkVal("bp_rd_en", fifoRdEn, 0);
         tick();
      end
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 12; i++) tick();
      checkVal("bp_n", accData.size(), 10);
      for (int i = 0; i < accData.size() && i < 10; i++) begin
         checkVal("bp_data", accData[i], 8'h20 + i);
         if (i >= 2) checkVal("bp_cycle", accCycle[i] - start, i + 7);
      end

      // Drain: enable drops the cycle after a read is issued
      doReset();
      for (int i = 0; i < 8; i++) pushWord(DW'(8'h40 + i));
      applyStimulus(1'b1, 1'b1);
      accData.delete(); accCycle.delete();
      readCount = 0;
      tick();
      applyStimulus(1'b0, 1'b1);
      tick();
      checkVal("drain_busy_mid", busy, 1);
      for (int i = 0; i < 5; i++) tick();
      checkVal("drain_reads", readCount, 1);
      checkVal("drain_n", accData.size(), 1);
      if (accData.size() > 0) checkVal("drain_word", accData[0], 8'h40);
      checkVal("drain_busy_end", busy, 0);

      // Empty boundary: a single word in the FIFO
      doReset();
      pushWord(8'h5A);
      applyStimulus(1'b1, 1'b1);
      readCount = 0; validCycles = 0;
      accData.delete(); accCycle.delete();
      for (int i = 0; i < 8; i++) tick();
      checkVal("empty_reads", readCount, 1);
      checkVal("empty_valid_cycles", validCycles, 1);
      checkVal("empty_n", accData.size(), 1);

      // Asynchronous reset with two words buffered
      doReset();
      for (int i = 0; i < 6; i++) pushWord(DW'(8'h60 + i));
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick();
      #1;
      checkVal("pre_rst_valid", outValid, 1);
      checkVal("pre_rst_rd_en", fifoRdEn, 0);
      doReset();
      applyStimulus(1'b1, 1'b1);
      validCycles = 0;
      for (int i = 0; i < 5; i++) tick();
      checkVal("post_rst_valid_cycles", validCycles, 0);
      checkVal("post_rst_count", wordCount, 0);
      checkVal("post_rst_busy", busy, 0);

      // Counter wrap: 18 words through a 4-bit counter
      doReset();
      for (int i = 0; i < 18; i++) pushWord(DW'(8'h80 + i));
      applyStimulus(1'b1, 1'b1);
      accData.delete(); accCycle.delete();
      for (int i = 0; i < 26; i++) tick();
      checkVal("wrap_n", accData.size(), 18);
      checkVal("wrap_count", wordCount, 2);

      // Random enable/ready/fill stress with occasional resets
      doReset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) != 0 && fifoQ.size() < 6) pushWord(DW'($urandom));
         applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6);
         if ($urandom_range(0, 799) == 0) doReset();
         tick();
      end
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 20; i++) tick();
      checkVal("stress_left", sentQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
